// File: rtl/gray_mon_pkg.sv
// Shared types and Gray helpers for the gray_monitor slice.
package gray_mon_pkg;

  localparam int unsigned GRAY_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  function automatic logic [GRAY_W-1:0] gray_to_bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = int'(GRAY_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_W-1:0] next_gray(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b = gray_to_bin(g) + GRAY_W'(1);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational 3-bit Gray-to-binary decoder.
module gray2bin
  import gray_mon_pkg::*;
(
  input  logic [GRAY_W-1:0] Gray,
  output logic [GRAY_W-1:0] Bin
);

  assign Bin = gray_to_bin(Gray);

endmodule

// File: rtl/gray_monitor.sv
// Checker/extender for the upstream 3-bit Gray counter.
// Define GRAY_MON_OVF_CHECK_EN to cross-check Overflow against the 100->000 wrap.
module gray_monitor
  import gray_mon_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [GRAY_W-1:0]    Gray,
  input  logic                 Overflow,
  input  logic                 Sync,
  output logic [GRAY_W-1:0]    Bin,
  output logic                 Step,
  output logic [CNT_WIDTH-1:0] Count,
  output logic [7:0]           Wraps,
  output logic                 Locked,
  output logic                 Error
);

  state_t            state;
  logic [GRAY_W-1:0] prev;
  logic [GRAY_W-1:0] bin_in;
  logic [GRAY_W-1:0] bin_prev;
  logic              step_ok;
  logic              wrap_ok;
  logic              ovf_bad;

  gray2bin u_dec_in   (.Gray(Gray), .Bin(bin_in));
  gray2bin u_dec_prev (.Gray(prev), .Bin(bin_prev));

  // A legal step is exactly +1 in the binary domain, modulo 8.
  assign step_ok = (bin_in == GRAY_W'(bin_prev + GRAY_W'(1)));
  assign wrap_ok = step_ok && (bin_in == '0);

`ifdef GRAY_MON_OVF_CHECK_EN
  logic ovf_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) ovf_q <= 1'b0;
    else       ovf_q <= Overflow;
  end

  // Overflow may only rise on the wrap step, and the wrap step must see it high.
  assign ovf_bad = (Overflow && !ovf_q && !wrap_ok) || (wrap_ok && !Overflow);
`else
  logic unused_ovf;
  assign unused_ovf = Overflow;
  assign ovf_bad    = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      prev   <= '0;
      Bin    <= '0;
      Step   <= 1'b0;
      Count  <= '0;
      Wraps  <= '0;
      Locked <= 1'b0;
      Error  <= 1'b0;
    end else begin
      Bin  <= bin_in;
      prev <= Gray;
      Step <= 1'b0;
      if (Sync) begin
        state  <= IDLE;
        Count  <= '0;
        Wraps  <= '0;
        Locked <= 1'b0;
        Error  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= TRACK;
            Locked <= 1'b1;
            Count  <= '0;
            Wraps  <= '0;
          end
          TRACK: begin
            if ((Gray != prev) || ovf_bad) begin
              if (step_ok && !ovf_bad) begin
                Step  <= 1'b1;
                Count <= Count + CNT_WIDTH'(1);
                if (wrap_ok && (Wraps != 8'hFF)) Wraps <= Wraps + 8'd1;
              end else begin
                state  <= FAULT;
                Locked <= 1'b0;
                Error  <= 1'b1;
              end
            end
          end
          FAULT: begin
            Error <= 1'b1;
          end
          default: begin
            state  <= IDLE;
            Locked <= 1'b0;
            Error  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
